// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back, write-allocate data cache controller
// Hits complete combinationally in IDLE; misses write back a dirty victim, then fill.
module dcache_ctrl #(
  parameter int LINE_COUNT = 4,
  parameter int WORD_SIZE  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   c_readC,
  input  logic                   c_writeC,
  input  logic [15:0]            c_address,
  input  logic [WORD_SIZE-1:0]   c_wdata,
  output logic [WORD_SIZE-1:0]   c_rdata,
  output logic                   c_readyC,
  output logic                   m_readM,
  output logic                   m_writeM,
  output logic [15:0]            m_address,
  output logic [4*WORD_SIZE-1:0] m_wdata,
  input  logic [4*WORD_SIZE-1:0] m_rdata,
  input  logic                   m_readyM,
  input  logic                   m_input_readyM,
  input  logic                   m_doneM,
  output logic [15:0]            hit_count,
  output logic [15:0]            miss_count
);

  localparam int IDX_W  = $clog2(LINE_COUNT);
  localparam int TAG_W  = 14 - IDX_W;
  localparam int LINE_W = 4 * WORD_SIZE;

  typedef enum logic [2:0] {
    IDLE,
    WB_REQ,
    WB_WAIT,
    FILL_REQ,
    FILL_WAIT
  } state_t;

  state_t             state_q;
  logic [LINE_COUNT-1:0] valid_q;
  logic [LINE_COUNT-1:0] dirty_q;
  logic [TAG_W-1:0]   tag_q  [LINE_COUNT];
  logic [LINE_W-1:0]  data_q [LINE_COUNT];
  logic [IDX_W-1:0]   miss_idx_q;
  logic [TAG_W-1:0]   miss_tag_q;
  logic [15:0]        m_address_q;
  logic [LINE_W-1:0]  m_wdata_q;
  logic [15:0]        hit_cnt_q;
  logic [15:0]        miss_cnt_q;

  logic [1:0]         req_off;
  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               req_active;
  logic               hit;
  logic               fill_now;
  logic [LINE_W-1:0]  cur_line;

  assign req_off    = c_address[1:0];
  assign req_idx    = c_address[2 +: IDX_W];
  assign req_tag    = c_address[15 -: TAG_W];
  assign req_active = c_readC | c_writeC;
  assign hit        = (state_q == IDLE) && req_active && valid_q[req_idx] &&
                      (tag_q[req_idx] == req_tag);
  assign fill_now   = (state_q == FILL_WAIT) && m_input_readyM;
  assign cur_line   = data_q[req_idx];

  assign c_readyC   = hit;
  assign c_rdata    = cur_line[int'(req_off) * WORD_SIZE +: WORD_SIZE];

  // Request pulses are gated by the live m_readyM so memory never sees one while busy;
  // the state advances on the same edge, so a pulse can never last two cycles.
  assign m_readM    = (state_q == FILL_REQ) && m_readyM;
  assign m_writeM   = (state_q == WB_REQ) && m_readyM;
  assign m_address  = m_address_q;
  assign m_wdata    = m_wdata_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

  always_ff @(posedge clk) begin
    if (hit && c_writeC) begin
      data_q[req_idx][int'(req_off) * WORD_SIZE +: WORD_SIZE] <= c_wdata;
    end else if (fill_now) begin
      data_q[miss_idx_q] <= m_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      miss_idx_q  <= '0;
      miss_tag_q  <= '0;
      m_address_q <= '0;
      m_wdata_q   <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      for (int i = 0; i < LINE_COUNT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (hit) begin
            if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
            if (c_writeC) dirty_q[req_idx] <= 1'b1;
          end else if (req_active) begin
            if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
            miss_idx_q <= req_idx;
            miss_tag_q <= req_tag;
            m_wdata_q  <= cur_line;
            if (valid_q[req_idx] && dirty_q[req_idx]) begin
              m_address_q <= {tag_q[req_idx], req_idx, 2'b00};
              state_q     <= WB_REQ;
            end else begin
              m_address_q <= {req_tag, req_idx, 2'b00};
              state_q     <= FILL_REQ;
            end
          end
        end
        WB_REQ: begin
          if (m_readyM) state_q <= WB_WAIT;
        end
        WB_WAIT: begin
          if (m_doneM) begin
            dirty_q[miss_idx_q] <= 1'b0;
            m_address_q         <= {miss_tag_q, miss_idx_q, 2'b00};
            state_q             <= FILL_REQ;
          end
        end
        FILL_REQ: begin
          if (m_readyM) state_q <= FILL_WAIT;
        end
        FILL_WAIT: begin
          if (m_input_readyM) begin
            valid_q[miss_idx_q] <= 1'b1;
            dirty_q[miss_idx_q] <= 1'b0;
            tag_q[miss_idx_q]   <= miss_tag_q;
            state_q             <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - self-checking bench for dcache_ctrl
// Table of CPU accesses against a small line memory, plus reset and stall sequences.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_readC, c_writeC;
  logic [15:0] c_address, c_wdata, c_rdata;
  logic        c_readyC;
  logic        m_readM, m_writeM;
  logic [15:0] m_address;
  logic [63:0] m_wdata, m_rdata;
  logic        m_readyM, m_input_readyM, m_doneM;
  logic [15:0] hit_count, miss_count;

  dcache_ctrl #(.LINE_COUNT(4), .WORD_SIZE(16)) dut (
    .clk(clk), .reset(reset),
    .c_readC(c_readC), .c_writeC(c_writeC), .c_address(c_address), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_readyC(c_readyC),
    .m_readM(m_readM), .m_writeM(m_writeM), .m_address(m_address), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_readyM(m_readyM), .m_input_readyM(m_input_readyM),
    .m_doneM(m_doneM), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int proto_viol = 0;

  logic [63:0] mem_line [64];

  logic [15:0] acc_rd;
  int          acc_mrd, acc_mwr, acc_first_k;
  logic [15:0] acc_rd_addr, acc_wb_addr;
  logic [63:0] acc_wb_data;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wd;
    logic [15:0] exp_rd;
    int          exp_mrd;
    int          exp_mwr;
    logic [15:0] exp_rd_addr;
    logic [15:0] exp_wb_addr;
    logic [63:0] exp_wb_data;
    logic [15:0] exp_hit;
    logic [15:0] exp_miss;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One CPU access with the memory model serviced inline; m_readyM is held low for the
  // first ready_delay cycles. Called and returns at posedge+1.
  task automatic access(input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                        input int ready_delay);
    int  pend_fill, pend_done;
    bit  prev_pulse, done;
    pend_fill = 0; pend_done = 0; prev_pulse = 0; done = 0;
    acc_mrd = 0; acc_mwr = 0; acc_first_k = -1; acc_rd = 'x;
    acc_rd_addr = 'x; acc_wb_addr = 'x; acc_wb_data = 'x;
    c_readC = !wr; c_writeC = wr; c_address = addr; c_wdata = wd;
    for (int k = 0; k < 60 && !done; k++) begin
      m_readyM = (k >= ready_delay);
      @(negedge clk);
      if ((m_readM || m_writeM) && (!m_readyM || prev_pulse)) proto_viol++;
      prev_pulse = m_readM || m_writeM;
      if (m_writeM) begin
        acc_mwr++; acc_wb_addr = m_address; acc_wb_data = m_wdata;
        mem_line[m_address[7:2]] = m_wdata;
        pend_done = 2;
      end
      if (m_readM) begin
        acc_mrd++; acc_rd_addr = m_address;
        if (acc_first_k < 0) acc_first_k = k;
        pend_fill = 2;
      end
      if (c_readyC) begin
        acc_rd = c_rdata;
        done = 1;
      end
      @(posedge clk); #1;
      m_input_readyM = 1'b0; m_doneM = 1'b0;
      if (pend_done > 0) begin
        pend_done--;
        if (pend_done == 0) m_doneM = 1'b1;
      end
      if (pend_fill > 0) begin
        pend_fill--;
        if (pend_fill == 0) begin
          m_rdata = mem_line[acc_rd_addr[7:2]];
          m_input_readyM = 1'b1;
          m_doneM = 1'b1;
        end
      end
    end
    c_readC = 1'b0; c_writeC = 1'b0; m_readyM = 1'b1;
    m_input_readyM = 1'b0; m_doneM = 1'b0;
    if (!done) begin
      errors++; checks++;
      $display("FAIL access_timeout: addr %h got no c_readyC, required c_readyC=1", addr);
    end
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < 64; i++) mem_line[i] = 64'h0;
    mem_line[0]  = 64'h0000_FFFF_0001_9023;
    mem_line[1]  = 64'h1003_1002_1001_1000;
    mem_line[3]  = 64'h3003_3002_3001_3000;
    mem_line[5]  = 64'h5003_5002_5001_5000;
    mem_line[8]  = 64'h2003_2002_2001_2000;
    mem_line[12] = 64'hC003_C002_C001_C000;
    mem_line[16] = 64'h4444_3333_2222_1111;

    vecs[0]  = '{0, 16'h0001, 16'h0, 16'h0001, 1, 0, 16'h0000, 16'h0, 64'h0, 16'd1, 16'd1};
    vecs[1]  = '{0, 16'h0002, 16'h0, 16'hFFFF, 0, 0, 16'h0, 16'h0, 64'h0, 16'd2, 16'd1};
    vecs[2]  = '{1, 16'h0003, 16'h1234, 16'h0, 0, 0, 16'h0, 16'h0, 64'h0, 16'd3, 16'd1};
    vecs[3]  = '{0, 16'h0041, 16'h0, 16'h2222, 1, 1, 16'h0040, 16'h0000,
                 64'h1234_FFFF_0001_9023, 16'd4, 16'd2};
    vecs[4]  = '{0, 16'h0000, 16'h0, 16'h9023, 1, 0, 16'h0000, 16'h0, 64'h0, 16'd5, 16'd3};
    vecs[5]  = '{0, 16'h0003, 16'h0, 16'h1234, 0, 0, 16'h0, 16'h0, 64'h0, 16'd6, 16'd3};
    vecs[6]  = '{1, 16'h0005, 16'hABCD, 16'h0, 1, 0, 16'h0004, 16'h0, 64'h0, 16'd7, 16'd4};
    vecs[7]  = '{0, 16'h0005, 16'h0, 16'hABCD, 0, 0, 16'h0, 16'h0, 64'h0, 16'd8, 16'd4};
    vecs[8]  = '{0, 16'h0004, 16'h0, 16'h1000, 0, 0, 16'h0, 16'h0, 64'h0, 16'd9, 16'd4};
    vecs[9]  = '{0, 16'h000C, 16'h0, 16'h3000, 1, 0, 16'h000C, 16'h0, 64'h0, 16'd10, 16'd5};
    vecs[10] = '{0, 16'h0015, 16'h0, 16'h5001, 1, 1, 16'h0014, 16'h0004,
                 64'h1003_1002_ABCD_1000, 16'd11, 16'd6};
    vecs[11] = '{0, 16'h0005, 16'h0, 16'hABCD, 1, 0, 16'h0004, 16'h0, 64'h0, 16'd12, 16'd7};

    c_readC = 0; c_writeC = 0; c_address = 0; c_wdata = 0;
    m_rdata = 0; m_readyM = 1; m_input_readyM = 0; m_doneM = 0;
    reset = 1'b1;
    #2;
    chk("rst_readyC", {63'd0, c_readyC}, 64'd0);
    chk("rst_mreq", {62'd0, m_readM, m_writeM}, 64'd0);
    chk("rst_maddr", {48'd0, m_address}, 64'd0);
    chk("rst_hits", {48'd0, hit_count}, 64'd0);
    chk("rst_miss", {48'd0, miss_count}, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 12; v++) begin
      access(vecs[v].wr, vecs[v].addr, vecs[v].wd, 0);
      if (!vecs[v].wr) chk($sformatf("v%0d_rdata", v), {48'd0, acc_rd}, {48'd0, vecs[v].exp_rd});
      chk($sformatf("v%0d_mreads", v), 64'(acc_mrd), 64'(vecs[v].exp_mrd));
      chk($sformatf("v%0d_mwrites", v), 64'(acc_mwr), 64'(vecs[v].exp_mwr));
      if (vecs[v].exp_mrd != 0)
        chk($sformatf("v%0d_rd_addr", v), {48'd0, acc_rd_addr}, {48'd0, vecs[v].exp_rd_addr});
      if (vecs[v].exp_mwr != 0) begin
        chk($sformatf("v%0d_wb_addr", v), {48'd0, acc_wb_addr}, {48'd0, vecs[v].exp_wb_addr});
        chk($sformatf("v%0d_wb_data", v), acc_wb_data, vecs[v].exp_wb_data);
      end
      @(negedge clk);
      chk($sformatf("v%0d_hits", v), {48'd0, hit_count}, {48'd0, vecs[v].exp_hit});
      chk($sformatf("v%0d_miss", v), {48'd0, miss_count}, {48'd0, vecs[v].exp_miss});
      @(posedge clk); #1;
    end

    // Memory busy for 10 cycles: the fill request must wait and pulse once.
    access(0, 16'h0020, 16'h0, 10);
    chk("stall_mreads", 64'(acc_mrd), 64'd1);
    chk("stall_first_cycle", 64'(acc_first_k), 64'd10);
    chk("stall_rd_addr", {48'd0, acc_rd_addr}, 64'h0020);
    chk("stall_rdata", {48'd0, acc_rd}, 64'h2000);
    @(negedge clk);
    chk("stall_hits", {48'd0, hit_count}, 64'd13);
    chk("stall_miss", {48'd0, miss_count}, 64'd8);

    // Reset while waiting for fill data, then a late fill must not update the line.
    @(posedge clk); #1;
    c_readC = 1'b1; c_address = 16'h0030;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (m_readM) seen = 1;
      @(posedge clk); #1;
    end
    chk("rst_fill_req_seen", {63'd0, seen}, 64'd1);
    c_readC = 1'b0;
    reset = 1'b1;
    #2;
    chk("midrst_hits", {48'd0, hit_count}, 64'd0);
    chk("midrst_miss", {48'd0, miss_count}, 64'd0);
    chk("midrst_mreq", {62'd0, m_readM, m_writeM}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_rdata = mem_line[12]; m_input_readyM = 1'b1; m_doneM = 1'b1;
    @(posedge clk); #1;
    m_input_readyM = 1'b0; m_doneM = 1'b0;
    access(0, 16'h0030, 16'h0, 0);
    chk("postrst_mreads", 64'(acc_mrd), 64'd1);
    chk("postrst_rdata", {48'd0, acc_rd}, 64'hC000);
    @(negedge clk);
    chk("postrst_miss", {48'd0, miss_count}, 64'd1);
    chk("postrst_hits", {48'd0, hit_count}, 64'd1);

    // Sustained hits drive hit_count past 0xFFFF; it must saturate.
    @(posedge clk); #1;
    c_readC = 1'b1; c_address = 16'h0030;
    repeat (65540) @(posedge clk);
    #1 c_readC = 1'b0;
    @(negedge clk);
    chk("sat_hits", {48'd0, hit_count}, 64'hFFFF);
    chk("sat_miss", {48'd0, miss_count}, 64'd1);

    chk("mem_protocol", 64'(proto_viol), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameter LINE_COUNT, default 4, number of direct-mapped lines (power of 2, 2..16).
REQ-002 Parameter WORD_SIZE, default 16, bits per word; a line is 4 words (4*WORD_SIZE bits).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 c_readC  input  1  CPU load request.
REQ-006 c_writeC  input  1  CPU store request; c_readC and c_writeC are never both 1.
REQ-007 c_address  input  16  CPU word address.
REQ-008 c_wdata  input  16  store data.
REQ-009 c_rdata  output  16  load data, valid while c_readyC=1 for a load.
REQ-010 c_readyC  output  1  request completes this cycle (combinational hit indication).
REQ-011 m_readM  output  1  line-read request to memory, single-cycle pulse.
REQ-012 m_writeM  output  1  line-write request to memory, single-cycle pulse.
REQ-013 m_address  output  16  line address to memory, bits [1:0] = 0.
REQ-014 m_wdata  output  64  write-back line, word k at bits [16k+15:16k].
REQ-015 m_rdata  input  64  fill line, same word packing, valid when m_input_readyM=1.
REQ-016 m_readyM  input  1  memory idle, can accept a request.
REQ-017 m_input_readyM  input  1  one-cycle pulse, fill data valid.
REQ-018 m_doneM  input  1  one-cycle pulse, memory operation finished.
REQ-019 hit_count, miss_count  output  16 each  access statistics.

Function
REQ-020 Address split: offset = c_address[1:0]; index = next log2(LINE_COUNT) bits; tag = remaining upper bits.
REQ-021 Per line: valid bit, dirty bit, tag, 4 data words; write-back, write-allocate policy.
REQ-022 States: IDLE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT.
REQ-023 Hit = state IDLE, request active, line valid, tag equal; c_readyC=1 in the same cycle, c_rdata = addressed word.
REQ-024 Store hit: addressed word replaced by c_wdata and dirty set at the rising edge; other words are unchanged.
REQ-025 Miss in IDLE: c_readyC=0; next state WB_REQ if the line is valid and dirty, otherwise FILL_REQ; miss request address latched.
REQ-026 WB_REQ: m_writeM=1, m_address={old tag,index,00}, m_wdata=line when m_readyM=1; next WB_WAIT; otherwise hold in WB_REQ.
REQ-027 WB_WAIT: m_wdata held; on m_doneM clear dirty, next FILL_REQ.
REQ-028 FILL_REQ: m_readM=1, m_address={new tag,index,00} when m_readyM=1; next FILL_WAIT.
REQ-029 FILL_WAIT: on m_input_readyM write m_rdata to line, set valid, clear dirty, set tag, next IDLE; the retried request then hits.
REQ-030 m_readM/m_writeM SHALL never be 1 for two consecutive cycles, and never while m_readyM=0.
REQ-031 CPU holds request stable until c_readyC=1; controller ignores request changes outside IDLE.
REQ-032 hit_count increments once per completed hit cycle; miss_count increments once per IDLE->miss transition; both saturate at 0xFFFF.
REQ-033 m_doneM pulse in FILL_WAIT (accompanying m_input_readyM) SHALL be ignored; m_input_readyM outside FILL_WAIT SHALL be ignored.

Reset
REQ-034 reset=1 asynchronously: state IDLE; all valid and dirty bits 0; hit_count=miss_count=0; m_readM=m_writeM=0; m_address=0; c_readyC=0.
REQ-035 Reset mid-miss aborts the transaction; no line is updated by a later m_input_readyM or m_doneM.
REQ-036 Data arrays need no reset.

Verification
REQ-037 After reset, load 0x0001 with memory[0..3]=9023,0001,FFFF,0000 -> one m_readM pulse at m_address 0x0000, fill, then c_readyC=1 with c_rdata=0x0001; miss_count=1, hit_count=1.
REQ-038 Then load 0x0002 -> c_readyC=1 in the same cycle, c_rdata=0xFFFF, no memory request; hit_count=2.
REQ-039 Store 0x1234 to 0x0003, then load 0x0041 (same index, LINE_COUNT=4) -> m_writeM pulse at m_address 0x0000 with m_wdata=0x1234_FFFF_0001_9023, then m_readM at 0x0040.
REQ-040 Request with m_readyM held 0 for 10 cycles -> m_readM stays 0; pulses exactly once in the first cycle m_readyM=1.
REQ-041 Assert reset during FILL_WAIT, then deliver m_input_readyM -> next load to the same address misses again (valid=0).
REQ-042 Force hit_count to 0xFFFF via repeated hits -> counter stays at 0xFFFF.
